// File: rtl/alu_seq_muldiv_if.sv
// Handshake bundle for the sequential execute-stage ALU.
// Decode side drives the op; writeback side takes result/cond.
interface alu_seq_muldiv_if #(
  parameter int WIDTH    = 32,
  parameter int ALU_OP_W = 4
);
  logic                kill;
  logic                in_valid;
  logic                in_ready;
  logic [ALU_OP_W-1:0] alu_op;
  logic                md_en;
  logic [2:0]          md_op;
  logic [2:0]          branch;
  logic [WIDTH-1:0]    op1;
  logic [WIDTH-1:0]    op2;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic                cond;

  modport master (
    output kill, in_valid, alu_op, md_en, md_op,
    output branch, op1, op2, out_ready,
    input  in_ready, out_valid, result, cond
  );

  modport slave (
    input  kill, in_valid, alu_op, md_en, md_op,
    input  branch, op1, op2, out_ready,
    output in_ready, out_valid, result, cond
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Sequential execute-stage ALU with iterative RV32M mul/div.
// Base ops finish in one cycle; mul/div take WIDTH+2 cycles.
module alu_seq_muldiv #(
  parameter int WIDTH    = 32,
  parameter int ALU_OP_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  alu_seq_muldiv_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(9);

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_JAL  = 3'd2;
  localparam logic [2:0] BR_JALR = 3'd3;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state;
  logic [SH_W-1:0]    cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic               neg;
  logic [2:0]         md_q;
  logic [WIDTH-1:0]   result_q;
  logic               cond_q;

  logic [SH_W-1:0]    sh;
  logic [WIDTH-1:0]   base_res;
  logic               base_cond;

  logic               sgn1;
  logic               sgn2;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               is_div;
  logic               is_rem;
  logic               div0;
  logic               ovf;
  logic [WIDTH-1:0]   spec_res;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fix_res;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.cond      = cond_q;

  assign sh = bus.op2[SH_W-1:0];

  // Single-cycle base ALU result
  always_comb begin
    base_res = bus.op1 + bus.op2;
    case (bus.alu_op)
      OP_AND:  base_res = bus.op1 & bus.op2;
      OP_OR:   base_res = bus.op1 | bus.op2;
      OP_XOR:  base_res = bus.op1 ^ bus.op2;
      OP_SLL:  base_res = bus.op1 << sh;
      OP_SRL:  base_res = bus.op1 >> sh;
      OP_SRA:  base_res = WIDTH'($signed(bus.op1) >>> sh);
      OP_SUB:  base_res = bus.op1 - bus.op2;
      OP_SLTU: base_res = WIDTH'(bus.op1 < bus.op2);
      OP_SLT:  base_res = WIDTH'($signed(bus.op1) < $signed(bus.op2));
      default: base_res = bus.op1 + bus.op2;
    endcase
  end

  // Branch-taken flag from the base result and operands
  always_comb begin
    base_cond = 1'b0;
    unique case (1'b1)
      bus.branch == BR_BEQ:  base_cond = (base_res == '0);
      bus.branch == BR_BNE:  base_cond = (base_res != '0);
      bus.branch == BR_JAL:  base_cond = 1'b1;
      bus.branch == BR_JALR: base_cond = 1'b1;
      bus.branch == BR_BLT:  base_cond = $signed(bus.op1) < $signed(bus.op2);
      bus.branch == BR_BGE:  base_cond = $signed(bus.op1) >= $signed(bus.op2);
      bus.branch == BR_BLTU: base_cond = bus.op1 < bus.op2;
      bus.branch == BR_BGEU: base_cond = bus.op1 >= bus.op2;
      default:               base_cond = 1'b0;
    endcase
  end

  // Operand magnitudes, result sign and divide special cases
  always_comb begin
    is_div = bus.md_op[2];
    is_rem = bus.md_op[2] & bus.md_op[1];
    sgn1   = (bus.md_op == MD_MULH) || (bus.md_op == MD_MULHSU) ||
             (bus.md_op == MD_DIV)  || (bus.md_op == MD_REM);
    sgn2   = (bus.md_op == MD_MULH) ||
             (bus.md_op == MD_DIV)  || (bus.md_op == MD_REM);
    a_neg  = sgn1 & bus.op1[WIDTH-1];
    b_neg  = sgn2 & bus.op2[WIDTH-1];
    a_mag  = a_neg ? -bus.op1 : bus.op1;
    b_mag  = b_neg ? -bus.op2 : bus.op2;
    div0   = is_div && (bus.op2 == '0);
    ovf    = sgn2 && is_div && (bus.op1 == MIN_VAL) &&
             (bus.op2 == '1);
    if (div0)
      spec_res = is_rem ? bus.op1 : '1;
    else
      spec_res = is_rem ? '0 : MIN_VAL;
  end

  // One shift-add and one restoring-divide step on acc
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    diff     = rem_sh - {1'b0, opb};
    if (diff[WIDTH])
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign fix-up and half/quotient/remainder select
  always_comb begin
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    case (md_q)
      MD_MUL:              fix_res = prod[WIDTH-1:0];
      MD_DIV, MD_DIVU:     fix_res = quo;
      MD_REM, MD_REMU:     fix_res = rem;
      default:             fix_res = prod[2*WIDTH-1:WIDTH];
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      neg      <= 1'b0;
      md_q     <= MD_MUL;
      result_q <= '0;
      cond_q   <= 1'b0;
    end else if (bus.kill && state != S_IDLE) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid && !bus.kill) begin
            if (!bus.md_en) begin
              result_q <= base_res;
              cond_q   <= base_cond;
              state    <= S_DONE;
            end else if (div0 || ovf) begin
              result_q <= spec_res;
              cond_q   <= 1'b0;
              state    <= S_DONE;
            end else begin
              acc    <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
              opb    <= is_div ? b_mag : a_mag;
              neg    <= is_rem ? a_neg : (a_neg ^ b_neg);
              md_q   <= bus.md_op;
              cnt    <= '0;
              cond_q <= 1'b0;
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc <= md_q[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == SH_W'(WIDTH-1))
            state <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_res;
          state    <= S_DONE;
        end
        default: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
